// File: rtl/ddr_cmd_bridge_if.sv
// Signal bundle between the DDR sequencer / read consumer side and the memory
// controller side of ddr_cmd_bridge.
interface ddr_cmd_bridge_if #(
   parameter int DATA_W = 64
);
   logic [24:0]       ddr_address;
   logic              ddr_wen;
   logic [DATA_W-1:0] wr_data;
   logic              fifo_write_en;
   logic              fifo_write_full;
   logic              fifo_write_almost_full;
   logic              fifo_read_en;
   logic              fifo_read_empty;
   logic [DATA_W-1:0] rd_data;
   logic [7:0]        address_tag_out;
   // mc_cmd: a command moves on a rising edge where mc_cmd_valid && mc_cmd_ready;
   // valid and the command fields stay frozen until then, ready may toggle freely.
   logic              mc_cmd_valid;
   logic              mc_cmd_ready;
   logic              mc_cmd_we;
   logic [24:0]       mc_cmd_addr;
   logic [DATA_W-1:0] mc_wr_data;
   logic              mc_rd_valid;
   logic [DATA_W-1:0] mc_rd_data;
   logic              err;

   modport slave (
      input  ddr_address, ddr_wen, wr_data, fifo_write_en, fifo_read_en,
             mc_cmd_ready, mc_rd_valid, mc_rd_data,
      output fifo_write_full, fifo_write_almost_full, fifo_read_empty, rd_data,
             address_tag_out, mc_cmd_valid, mc_cmd_we, mc_cmd_addr, mc_wr_data, err
   );

   modport master (
      output ddr_address, ddr_wen, wr_data, fifo_write_en, fifo_read_en,
             mc_cmd_ready, mc_rd_valid, mc_rd_data,
      input  fifo_write_full, fifo_write_almost_full, fifo_read_empty, rd_data,
             address_tag_out, mc_cmd_valid, mc_cmd_we, mc_cmd_addr, mc_wr_data, err
   );
endinterface

// File: rtl/ddr_cmd_bridge.sv
// Command FIFO + read-credit scheduler + in-order read-return FIFO between a DDR
// sequencer and a memory controller. sched_state exposes the scheduler FSM.
module ddr_cmd_bridge #(
   parameter int DATA_W    = 64,
   parameter int CMD_DEPTH = 16,
   parameter int RD_DEPTH  = 16,
   parameter int AF_MARGIN = 4
) (
   input  logic            clk_100,
   input  logic            rst,
   ddr_cmd_bridge_if.slave bus,
   output logic [1:0]      sched_state
);
   localparam int CP_W  = $clog2(CMD_DEPTH);
   localparam int CC_W  = CP_W + 1;
   localparam int RP_W  = $clog2(RD_DEPTH);
   localparam int RC_W  = RP_W + 1;
   localparam int RS_W  = RC_W + 1;
   localparam int CMD_W = 1 + 25 + DATA_W;
   localparam int RET_W = 8 + DATA_W;

   localparam logic [CC_W-1:0] CMD_FULL_LVL  = CC_W'(CMD_DEPTH);
   localparam logic [CC_W-1:0] CMD_AF_LVL    = CC_W'(CMD_DEPTH - AF_MARGIN);
   localparam logic [RS_W-1:0] RD_CREDIT_LIM = RS_W'(RD_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_HOLD_RD = 2'd2
   } sched_t;

   sched_t            state, state_nx;

   logic [CMD_W-1:0]  cmd_mem [CMD_DEPTH];
   logic [CP_W-1:0]   cmd_wptr, cmd_rptr, cmd_rptr_nx;
   logic [CC_W-1:0]   cmd_cnt, cmd_cnt_nx;

   logic [RET_W-1:0]  ret_mem [RD_DEPTH];
   logic [RP_W-1:0]   ret_wptr, ret_rptr, ret_rptr_nx;
   logic [RC_W-1:0]   ret_cnt, ret_cnt_nx;

   logic [7:0]        tag_mem [RD_DEPTH];
   logic [RP_W-1:0]   tag_wptr, tag_rptr;
   logic [RC_W-1:0]   outstanding, out_nx;

   logic              cmd_valid_q, cmd_we_q;
   logic [24:0]       cmd_addr_q;
   logic [DATA_W-1:0] cmd_data_q;
   logic              full_q, afull_q, empty_q, err_q;
   logic [DATA_W-1:0] rd_data_q;
   logic [7:0]        tag_q;

   logic              cmd_push, cmd_pop, rd_issue, ret_push, ret_pop, credit_nx;
   logic              err_evt;
   logic [CMD_W-1:0]  cmd_in, cmd_head_nx;
   logic [RET_W-1:0]  ret_in, ret_head_nx;

   always_comb begin
      cmd_push    = bus.fifo_write_en && (cmd_cnt != CMD_FULL_LVL);
      cmd_pop     = cmd_valid_q && bus.mc_cmd_ready;
      rd_issue    = cmd_pop && !cmd_we_q;
      ret_push    = bus.mc_rd_valid && (outstanding != '0);
      ret_pop     = bus.fifo_read_en && !empty_q;
      err_evt     = (bus.fifo_write_en && (cmd_cnt == CMD_FULL_LVL)) ||
                    (bus.fifo_read_en && empty_q) ||
                    (bus.mc_rd_valid && (outstanding == '0));

      cmd_cnt_nx  = cmd_cnt + CC_W'(cmd_push) - CC_W'(cmd_pop);
      cmd_rptr_nx = cmd_rptr + CP_W'(cmd_pop);
      cmd_in      = {bus.ddr_wen, bus.ddr_address, bus.wr_data};
      // A push landing on the next head slot means the FIFO was otherwise empty.
      cmd_head_nx = (cmd_push && (cmd_wptr == cmd_rptr_nx)) ? cmd_in : cmd_mem[cmd_rptr_nx];

      out_nx      = outstanding + RC_W'(rd_issue) - RC_W'(ret_push);
      ret_cnt_nx  = ret_cnt + RC_W'(ret_push) - RC_W'(ret_pop);
      ret_rptr_nx = ret_rptr + RP_W'(ret_pop);
      ret_in      = {tag_mem[tag_rptr], bus.mc_rd_data};
      ret_head_nx = (ret_push && (ret_wptr == ret_rptr_nx)) ? ret_in : ret_mem[ret_rptr_nx];

      // Every issued read must have a guaranteed slot in the return FIFO.
      credit_nx   = ({1'b0, out_nx} + {1'b0, ret_cnt_nx}) < RD_CREDIT_LIM;

      state_nx    = ST_IDLE;
      if (cmd_cnt_nx != '0) begin
         if (cmd_head_nx[CMD_W-1] || credit_nx) state_nx = ST_ISSUE;
         else                                   state_nx = ST_HOLD_RD;
      end
   end

   always_ff @(posedge clk_100) begin
      if (!rst) begin
         if (cmd_push) cmd_mem[cmd_wptr] <= cmd_in;
         if (rd_issue) tag_mem[tag_wptr] <= cmd_addr_q[7:0];
         if (ret_push) ret_mem[ret_wptr] <= ret_in;
      end
   end

   always_ff @(posedge clk_100) begin
      if (rst) begin
         state       <= ST_IDLE;
         cmd_wptr    <= '0;
         cmd_rptr    <= '0;
         cmd_cnt     <= '0;
         ret_wptr    <= '0;
         ret_rptr    <= '0;
         ret_cnt     <= '0;
         tag_wptr    <= '0;
         tag_rptr    <= '0;
         outstanding <= '0;
         cmd_valid_q <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_data_q  <= '0;
         full_q      <= 1'b0;
         afull_q     <= 1'b0;
         empty_q     <= 1'b1;
         err_q       <= 1'b0;
         rd_data_q   <= '0;
         tag_q       <= '0;
      end else begin
         state       <= state_nx;
         cmd_wptr    <= cmd_wptr + CP_W'(cmd_push);
         cmd_rptr    <= cmd_rptr_nx;
         cmd_cnt     <= cmd_cnt_nx;
         ret_wptr    <= ret_wptr + RP_W'(ret_push);
         ret_rptr    <= ret_rptr_nx;
         ret_cnt     <= ret_cnt_nx;
         tag_wptr    <= tag_wptr + RP_W'(rd_issue);
         tag_rptr    <= tag_rptr + RP_W'(ret_push);
         outstanding <= out_nx;

         cmd_valid_q <= (state_nx == ST_ISSUE);
         if (cmd_cnt_nx != '0) {cmd_we_q, cmd_addr_q, cmd_data_q} <= cmd_head_nx;
         else                  {cmd_we_q, cmd_addr_q, cmd_data_q} <= '0;

         full_q      <= (cmd_cnt_nx == CMD_FULL_LVL);
         afull_q     <= (cmd_cnt_nx >= CMD_AF_LVL);
         empty_q     <= (ret_cnt_nx == '0);
         err_q       <= err_q | err_evt;

         if (ret_cnt_nx != '0) {tag_q, rd_data_q} <= ret_head_nx;
         else                  {tag_q, rd_data_q} <= '0;
      end
   end

   assign bus.mc_cmd_valid           = cmd_valid_q;
   assign bus.mc_cmd_we              = cmd_we_q;
   assign bus.mc_cmd_addr            = cmd_addr_q;
   assign bus.mc_wr_data             = cmd_data_q;
   assign bus.fifo_write_full        = full_q;
   assign bus.fifo_write_almost_full = afull_q;
   assign bus.fifo_read_empty        = empty_q;
   assign bus.rd_data                = rd_data_q;
   assign bus.address_tag_out        = tag_q;
   assign bus.err                    = err_q;
   assign sched_state                = state;
endmodule

// File: tb/tb_ddr_cmd_bridge.sv
// Self-checking bench for ddr_cmd_bridge: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_ddr_cmd_bridge;
   localparam int DATA_W    = 64;
   localparam int CMD_DEPTH = 16;
   localparam int RD_DEPTH  = 16;
   localparam int AF_MARGIN = 4;
   localparam int CMD_W     = 1 + 25 + DATA_W;
   localparam int RET_W     = 8 + DATA_W;

   // ---------------- clock / reset ----------------
   logic       clk_100 = 1'b0;
   logic       rst;
   logic [1:0] sched_state;
   always #5 clk_100 = ~clk_100;

   ddr_cmd_bridge_if #(.DATA_W(DATA_W)) bus ();

   ddr_cmd_bridge #(
      .DATA_W(DATA_W), .CMD_DEPTH(CMD_DEPTH), .RD_DEPTH(RD_DEPTH), .AF_MARGIN(AF_MARGIN)
   ) dut (
      .clk_100(clk_100),
      .rst(rst),
      .bus(bus),
      .sched_state(sched_state)
   );

   // ---------------- reference model / scoreboard ----------------
   logic [CMD_W-1:0] m_cmd_q[$];   // accepted, not yet transferred commands
   logic [7:0]       m_tag_q[$];   // issued reads awaiting return
   logic [RET_W-1:0] exp_q[$];     // expected read-return FIFO contents
   bit               m_valid;
   bit               m_err;
   int               checks;
   int               errors;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      rst               = 1'b0;
      bus.ddr_address   = '0;
      bus.ddr_wen       = 1'b0;
      bus.wr_data       = '0;
      bus.fifo_write_en = 1'b0;
      bus.fifo_read_en  = 1'b0;
      bus.mc_cmd_ready  = 1'b0;
      bus.mc_rd_valid   = 1'b0;
      bus.mc_rd_data    = '0;
   endtask

   // One clock: update the model from the inputs seen at the edge, then compare.
   task automatic cycle();
      logic [CMD_W-1:0] c = '0;
      bit               xfer;
      logic [1:0]       exp_state;
      @(posedge clk_100);
      if (rst) begin
         m_cmd_q.delete();
         m_tag_q.delete();
         exp_q.delete();
         m_valid = 1'b0;
         m_err   = 1'b0;
      end else begin
         xfer = m_valid && bus.mc_cmd_ready;
         if (bus.fifo_write_en) begin
            if (m_cmd_q.size() == CMD_DEPTH) m_err = 1'b1;
            else m_cmd_q.push_back({bus.ddr_wen, bus.ddr_address, bus.wr_data});
         end
         if (xfer) c = m_cmd_q.pop_front();
         if (bus.fifo_read_en) begin
            if (exp_q.size() == 0) m_err = 1'b1;
            else void'(exp_q.pop_front());
         end
         if (bus.mc_rd_valid) begin
            if (m_tag_q.size() == 0) m_err = 1'b1;
            else exp_q.push_back({m_tag_q.pop_front(), bus.mc_rd_data});
         end
         if (xfer && !c[CMD_W-1]) m_tag_q.push_back(c[DATA_W+7:DATA_W]);
         m_valid = (m_cmd_q.size() > 0) &&
                   (m_cmd_q[0][CMD_W-1] || (m_tag_q.size() + exp_q.size() < RD_DEPTH));
      end
      #1;
      exp_state = (m_cmd_q.size() == 0) ? 2'd0 : (m_valid ? 2'd1 : 2'd2);
      chk("cmd_valid", bus.mc_cmd_valid, m_valid);
      if (m_valid) chk("cmd_head", {bus.mc_cmd_we, bus.mc_cmd_addr, bus.mc_wr_data}, m_cmd_q[0]);
      chk("sched_state", sched_state, exp_state);
      chk("wr_full", bus.fifo_write_full, m_cmd_q.size() == CMD_DEPTH);
      chk("wr_afull", bus.fifo_write_almost_full, m_cmd_q.size() >= CMD_DEPTH - AF_MARGIN);
      chk("rd_empty", bus.fifo_read_empty, exp_q.size() == 0);
      if (exp_q.size() != 0) chk("rd_head", {bus.address_tag_out, bus.rd_data}, exp_q[0]);
      chk("err", bus.err, m_err);
   endtask

   task automatic chk_reset_values();
      chk("rst_valid", bus.mc_cmd_valid, 1'b0);
      chk("rst_full", bus.fifo_write_full, 1'b0);
      chk("rst_afull", bus.fifo_write_almost_full, 1'b0);
      chk("rst_empty", bus.fifo_read_empty, 1'b1);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_rd_data", bus.rd_data, '0);
      chk("rst_tag", bus.address_tag_out, '0);
      chk("rst_cmd", {bus.mc_cmd_we, bus.mc_cmd_addr, bus.mc_wr_data}, '0);
      chk("rst_state", sched_state, 2'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        push;
      logic        wen;
      logic [24:0] addr;
      logic        ready;
      logic        e_valid;
      logic        e_we;
      logic [24:0] e_addr;
      logic        e_af;
      logic        e_full;
      logic        e_err;
      logic [1:0]  e_state;
   } vec_t;

   vec_t vecs[19];

   initial begin
      int pop_pct;
      checks = 0;
      errors = 0;
      m_valid = 1'b0;
      m_err   = 1'b0;

      vecs[0] = '{push: 1'b1, wen: 1'b1, addr: 25'h0000123, ready: 1'b1, e_valid: 1'b1,
                  e_we: 1'b1, e_addr: 25'h0000123, e_af: 1'b0, e_full: 1'b0, e_err: 1'b0,
                  e_state: 2'd1};
      vecs[1] = '{push: 1'b0, wen: 1'b0, addr: 25'h0, ready: 1'b1, e_valid: 1'b0,
                  e_we: 1'b0, e_addr: 25'h0, e_af: 1'b0, e_full: 1'b0, e_err: 1'b0,
                  e_state: 2'd0};
      for (int i = 0; i < 17; i++) begin
         vecs[2+i] = '{push: 1'b1, wen: 1'b1, addr: 25'(32'h100 + i), ready: 1'b0,
                       e_valid: 1'b1, e_we: 1'b1, e_addr: 25'h100, e_af: (i + 1 >= 12),
                       e_full: (i >= 15), e_err: (i == 16), e_state: 2'd1};
      end

      // reset values
      drive_idle();
      rst = 1'b1;
      cycle();
      cycle();
      chk_reset_values();
      rst = 1'b0;

      // single write handshake, then fill to almost-full / full / overflow
      for (int k = 0; k < 19; k++) begin
         drive_idle();
         bus.fifo_write_en = vecs[k].push;
         bus.ddr_wen       = vecs[k].wen;
         bus.ddr_address   = vecs[k].addr;
         bus.wr_data       = 64'(k);
         bus.mc_cmd_ready  = vecs[k].ready;
         cycle();
         chk($sformatf("tv%0d_valid", k), bus.mc_cmd_valid, vecs[k].e_valid);
         if (vecs[k].e_valid) begin
            chk($sformatf("tv%0d_we", k), bus.mc_cmd_we, vecs[k].e_we);
            chk($sformatf("tv%0d_addr", k), bus.mc_cmd_addr, vecs[k].e_addr);
         end
         chk($sformatf("tv%0d_afull", k), bus.fifo_write_almost_full, vecs[k].e_af);
         chk($sformatf("tv%0d_full", k), bus.fifo_write_full, vecs[k].e_full);
         chk($sformatf("tv%0d_err", k), bus.err, vecs[k].e_err);
         chk($sformatf("tv%0d_state", k), sched_state, vecs[k].e_state);
      end

      // drain the full FIFO; model checks order of the 16 surviving commands
      drive_idle();
      bus.mc_cmd_ready = 1'b1;
      for (int t = 0; t < 17; t++) cycle();
      chk("drain_valid", bus.mc_cmd_valid, 1'b0);
      chk("drain_full", bus.fifo_write_full, 1'b0);

      drive_idle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;

      // 17 reads with returns enabled but no consumer pops: 17th must wait for credit
      for (int t = 0; t < 30; t++) begin
         drive_idle();
         bus.fifo_write_en = (t < 17);
         bus.ddr_wen       = 1'b0;
         bus.ddr_address   = 25'(32'h200 + t);
         bus.mc_cmd_ready  = 1'b1;
         bus.mc_rd_valid   = (m_tag_q.size() > 0);
         bus.mc_rd_data    = 64'(32'hD000 + t);
         cycle();
      end
      chk("hold_valid", bus.mc_cmd_valid, 1'b0);
      chk("hold_state", sched_state, 2'd2);
      chk("hold_empty", bus.fifo_read_empty, 1'b0);
      drive_idle();
      bus.fifo_read_en = 1'b1;
      cycle();
      chk("credit_valid", bus.mc_cmd_valid, 1'b1);
      chk("credit_addr", bus.mc_cmd_addr, 25'h210);
      drive_idle();
      bus.mc_cmd_ready = 1'b1;
      cycle();
      chk("credit_issued", bus.mc_cmd_valid, 1'b0);

      // reset mid-operation with a read return present, then a stray return
      drive_idle();
      rst = 1'b1;
      bus.mc_rd_valid = 1'b1;
      bus.mc_rd_data  = 64'hDEAD;
      cycle();
      chk("midrst_empty", bus.fifo_read_empty, 1'b1);
      chk("midrst_valid", bus.mc_cmd_valid, 1'b0);
      drive_idle();
      bus.mc_rd_valid = 1'b1;
      bus.mc_rd_data  = 64'h77;
      cycle();
      chk("stray_empty", bus.fifo_read_empty, 1'b1);
      chk("stray_err", bus.err, 1'b1);
      drive_idle();
      bus.fifo_read_en = 1'b1;
      cycle();
      drive_idle();
      rst = 1'b1;
      cycle();
      chk_reset_values();

      // single read round trip with tag
      drive_idle();
      bus.fifo_write_en = 1'b1;
      bus.ddr_wen       = 1'b0;
      bus.ddr_address   = 25'h1ABCDEF;
      cycle();
      chk("rd1_valid", bus.mc_cmd_valid, 1'b1);
      chk("rd1_we", bus.mc_cmd_we, 1'b0);
      chk("rd1_addr", bus.mc_cmd_addr, 25'h1ABCDEF);
      drive_idle();
      bus.mc_cmd_ready = 1'b1;
      cycle();
      chk("rd1_sent", bus.mc_cmd_valid, 1'b0);
      drive_idle();
      bus.mc_rd_valid = 1'b1;
      bus.mc_rd_data  = 64'hA5;
      cycle();
      chk("rd1_empty", bus.fifo_read_empty, 1'b0);
      chk("rd1_data", bus.rd_data, 64'hA5);
      chk("rd1_tag", bus.address_tag_out, 8'hEF);
      drive_idle();
      bus.fifo_read_en = 1'b1;
      cycle();
      chk("rd1_popped", bus.fifo_read_empty, 1'b1);
      chk("rd1_err", bus.err, 1'b0);

      // randomized legal traffic; consumer speed alternates to force credit stalls
      for (int t = 0; t < 10000; t++) begin
         pop_pct = ((t / 1000) % 2 == 1) ? 15 : 70;
         drive_idle();
         bus.fifo_write_en = (m_cmd_q.size() < CMD_DEPTH) && ($urandom_range(0, 99) < 55);
         bus.ddr_wen       = 1'($urandom_range(0, 1));
         bus.ddr_address   = 25'($urandom);
         bus.wr_data       = {$urandom, $urandom};
         bus.mc_cmd_ready  = ($urandom_range(0, 99) < 60);
         bus.mc_rd_valid   = (m_tag_q.size() > 0) && ($urandom_range(0, 99) < 60);
         bus.mc_rd_data    = {$urandom, $urandom};
         bus.fifo_read_en  = (exp_q.size() > 0) && ($urandom_range(0, 99) < pop_pct);
         cycle();
      end
      chk("rand_err", bus.err, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ddr_cmd_bridge.md
DDR_CMD_BRIDGE -- requirements
Module: ddr_cmd_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of write and read data words.
REQ-002 SHALL have parameter CMD_DEPTH, default 16: command FIFO entries (power of 2).
REQ-003 SHALL have parameter RD_DEPTH, default 16: read-return FIFO entries (power of 2).
REQ-004 SHALL have parameter AF_MARGIN, default 4: free-entry threshold for almost-full.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk_100  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous reset, active high.
REQ-008 ddr_address  in  25  command word address from the DDR interface sequencer.
REQ-009 ddr_wen  in  1  command type: 1 write, 0 read.
REQ-010 wr_data  in  DATA_W  write data, captured with the command.
REQ-011 fifo_write_en  in  1  push {ddr_wen, ddr_address, wr_data} into the command FIFO.
REQ-012 fifo_write_full  out  1  command FIFO count == CMD_DEPTH.
REQ-013 fifo_write_almost_full  out  1  command FIFO count >= CMD_DEPTH-AF_MARGIN.
REQ-014 fifo_read_en  in  1  pop head of read-return FIFO.
REQ-015 fifo_read_empty  out  1  read-return FIFO count == 0.
REQ-016 rd_data  out  DATA_W  head data of read-return FIFO (first-word fall-through).
REQ-017 address_tag_out  out  8  ddr_address[7:0] of the read that produced rd_data.
REQ-018 mc_cmd_valid / mc_cmd_ready  out / in  1 / 1  command handshake to memory controller.
REQ-019 mc_cmd_we, mc_cmd_addr, mc_wr_data  out  1, 25, DATA_W  head command fields.
REQ-020 mc_rd_valid, mc_rd_data  in  1, DATA_W  in-order read returns from memory controller.
REQ-021 err  out  1  sticky protocol-error flag.

Function
REQ-022 Command transfer SHALL occur in a cycle with mc_cmd_valid && mc_cmd_ready; the head is then popped.
REQ-023 mc_cmd_valid and mc_cmd_* SHALL be registered and stay stable until transfer.
REQ-024 A push into an empty command FIFO SHALL raise mc_cmd_valid no earlier and no later than the next cycle (latency 1) when issue is permitted.
REQ-025 Scheduler FSM states SHALL be IDLE, ISSUE, HOLD_RD: IDLE when FIFO empty; ISSUE while head presented; HOLD_RD when head is a read lacking credit.
REQ-026 Read credit SHALL exist iff outstanding + rd_count < RD_DEPTH; in HOLD_RD mc_cmd_valid SHALL be 0 and writes behind the head SHALL NOT bypass it.
REQ-027 HOLD_RD -> ISSUE SHALL occur the cycle after credit becomes available; ISSUE -> IDLE after the last transfer empties the FIFO.
REQ-028 On each read transfer, addr[7:0] SHALL be pushed into an internal tag queue and outstanding incremented.
REQ-029 On mc_rd_valid, the tag head and mc_rd_data SHALL be written to the read-return FIFO and outstanding decremented; fifo_read_empty SHALL fall the next cycle.
REQ-030 Outstanding counter SHALL be clog2(RD_DEPTH)+1 bits; simultaneous issue and return SHALL leave it unchanged.
REQ-031 Push while fifo_write_full SHALL be dropped and set err, even with a same-cycle pop.
REQ-032 Push and pop in the same cycle with FIFO neither full nor empty SHALL leave the count unchanged.
REQ-033 fifo_read_en while fifo_read_empty SHALL be ignored and set err.
REQ-034 mc_rd_valid with outstanding == 0 SHALL drop the data and set err.
REQ-035 fifo_read_en and mc_rd_valid in the same cycle SHALL pop and push concurrently, including when the FIFO holds exactly one entry.
REQ-036 FIFO pointers SHALL wrap modulo depth without loss.
REQ-037 All flags SHALL be registered outputs derived from post-update counts.

Reset
REQ-038 On rst: both FIFOs, tag queue and outstanding SHALL clear; state = IDLE; mc_cmd_valid=0, fifo_write_full=0, fifo_write_almost_full=0, fifo_read_empty=1, err=0, rd_data=0, address_tag_out=0, mc_cmd_*=0.
REQ-039 rst asserted mid-operation SHALL discard queued commands and outstanding reads; mc_rd_valid during rst SHALL be ignored.

Verification
REQ-040 Push write addr 0x0000123, mc_cmd_ready=1 -> mc_cmd_valid=1 next cycle, mc_cmd_we=1, addr 0x0000123, FIFO empty after transfer.
REQ-041 Push 12 commands with mc_cmd_ready=0 -> almost_full=1 after 12th; 16 pushes -> full=1; 17th push -> dropped, err=1.
REQ-042 Issue 16 reads, no pops, returns enabled -> 17th read held in HOLD_RD, mc_cmd_valid=0 until one fifo_read_en, then issued.
REQ-043 Read addr 0x1ABCDEF returns data 0xA5 -> fifo_read_empty=0 next cycle, rd_data=0xA5, address_tag_out=0xEF.
REQ-044 mc_rd_valid with no reads outstanding -> data dropped, fifo_read_empty stays 1, err=1; then rst -> err=0, all flags at reset values.
REQ-045 Random push/pop/ready/return for 10000 cycles, depths wrapped >=5 times -> command and read order preserved, counts match model, err=0.
